snake_audio: RTL and testbench
==============================

# snake_audio

Sound-effect generator for the Snake game. It runs on the 100 MHz system clock and watches the push buttons, the screen-select switch, the game-over flag and the eat-event bus. It drives a single-bit square-wave tone onto the board's mono PWM amplifier (AUD_PWM) and holds the amplifier enable (AUD_SD). It sits beside the VGA/game logic, which feeds it its status signals.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency (documentation only; all timing below is in cycles).
- GO_HALF, 250_000, half-period of the game-over tone (200 Hz).
- EAT_HALF, 50_000, half-period of the eat chirp (1 kHz).
- BTN_HALF, 25_000, half-period of the button click (2 kHz).
- EAT_DUR, 10_000_000, eat chirp length in cycles (100 ms).
- BTN_DUR, 2_000_000, button click length in cycles (20 ms).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- pbttn  in  5  raw push buttons {BTND, BTNR, BTNL, BTNU, BTNC}, active-high.
- switch_screen  in  1  1 = game map shown, 0 = start screen.
- gameover  in  1  level, 1 while the game is lost.
- ate  in  16  eat-event bus; any change in its value is one eat event.
- AUD_PWM  out  1  square-wave tone output, 0 when silent.
- AUD_SD  out  1  amplifier enable.

## Operation
- Input conditioning:
  - All inputs pass through a 2-flop synchronizer.
  - Button event: rising edge of any synchronized pbttn bit.
  - Eat event: the synchronized ate differs from its previous synchronized sample.
- Eat chirp:
  - An eat event loads the eat timer with EAT_DUR.
  - The timer decrements each cycle down to 0.
  - A new event while the timer is running reloads it (retrigger).
- Button click:
  - A button event loads the button timer with BTN_DUR, same rules as the eat timer.
  - Clicks are generated on both screens.
- Game-over tone: active while synchronized gameover=1 AND synchronized switch_screen=1.
- Tone select, fixed priority:
  - GAMEOVER (GO_HALF) over EAT (eat timer ≠ 0, EAT_HALF) over BTN (button timer ≠ 0, BTN_HALF) over SILENT.
  - Lower-priority timers keep counting while masked. A click that outlasts a chirp becomes audible when the chirp ends.
- Tone generator:
  - One phase counter, 0 .. half−1.
  - When the selected tone changes, including from SILENT, the counter clears and AUD_PWM is set to 1.
  - After that, AUD_PWM toggles each time the counter reaches half−1, and the counter wraps to 0. Result: 50% duty, period 2·half cycles.
  - SILENT: AUD_PWM=0 and the counter is held at 0.
- AUD_SD: 1 whenever reset is deasserted. It is 0 only during reset.

## Timing
- Reset (reset=0, asynchronous):
  - AUD_PWM=0, AUD_SD=0.
  - Timers, phase counter, synchronizers and previous-sample registers all cleared; tone select = SILENT.
  - Asserting reset mid-tone silences the output immediately.
  - After release, ate's first synchronized value is captured without producing an event.
- Latency: an input change at edge N produces its first AUD_PWM=1 at edge N+4.
  - 2 cycles of synchronization.
  - 1 cycle of edge/change detection and timer load.
  - 1 cycle to register the tone select and output.
- Chirp/click length: the timer is nonzero for exactly EAT_DUR/BTN_DUR cycles after load, so audible length equals DUR cycles, ±1 for output registering.
- Game-over dropping to 0, or switch_screen dropping to 0, releases GAMEOVER 3 cycles later. The next tone (or silence) applies from that point.
- Simultaneous eat and button events: both timers load; EAT is heard.
- Timers are 24 bits minimum and the phase counter 18 bits minimum. No wrap-around below 0: timers saturate at 0.

## Test plan
Use the small parameters GO_HALF=8, EAT_HALF=4, BTN_HALF=2, EAT_DUR=40, BTN_DUR=20.
- Reset held low: AUD_PWM=0 and AUD_SD=0 regardless of inputs. Release: AUD_SD=1 next edge, AUD_PWM stays 0, no spurious eat event from the initial ate value.
- Pulse pbttn[0] high for 1 cycle at edge N:
  - AUD_PWM rises at N+4 and toggles every 2 cycles.
  - Silence after 20 cycles.
  - Holding the button produces one click only.
- Change ate from 16'h0000 to 16'h0001:
  - Square wave with period 8 cycles for 40 cycles.
  - A second change at cycle 20 extends the chirp to 40 cycles from the second event.
- gameover=1 with switch_screen=1: continuous period-16 wave until gameover drops, then silence 3 cycles later. The same stimulus with switch_screen=0 gives silence.
- Priority:
  - gameover=1 plus an eat event: the output stays at period 16.
  - Eat event plus button event in the same cycle: period 8 for 40 cycles; the button timer has expired, so silence follows.
- Mid-chirp reset: assert reset during an eat chirp. AUD_PWM=0 immediately. After release, silence until a new event.

Source files
------------

// File: rtl/snake_audio.sv
`default_nettype none
// ============================================================================
// Module   : snake_audio
// Brief    : Sound-effect generator for the Snake game. Produces a 1-bit
//            square-wave tone for the mono PWM amplifier: game-over drone,
//            eat chirp and button click, selected by fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module snake_audio #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int GO_HALF  = 250_000,
    parameter int EAT_HALF = 50_000,
    parameter int BTN_HALF = 25_000,
    parameter int EAT_DUR  = 10_000_000,
    parameter int BTN_DUR  = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  pbttn,
    input  logic        switch_screen,
    input  logic        gameover,
    input  logic [15:0] ate,
    output logic        AUD_PWM,
    output logic        AUD_SD
);

    localparam logic [17:0] c_go_half_m1  = 18'(GO_HALF - 1);
    localparam logic [17:0] c_eat_half_m1 = 18'(EAT_HALF - 1);
    localparam logic [17:0] c_btn_half_m1 = 18'(BTN_HALF - 1);
    localparam logic [23:0] c_eat_dur     = 24'(EAT_DUR);
    localparam logic [23:0] c_btn_dur     = 24'(BTN_DUR);
    // Amplifier stays enabled out of reset for any meaningful clock setting.
    localparam logic        c_sd_on       = (CLK_HZ > 0);

    typedef enum logic [1:0] {
        TONE_SILENT = 2'd0,
        TONE_BTN    = 2'd1,
        TONE_EAT    = 2'd2,
        TONE_GO     = 2'd3
    } tone_t;

    logic [4:0]  r_btn_s1, r_btn_s2, r_btn_prev;
    logic [15:0] r_ate_s1, r_ate_s2, r_ate_prev;
    logic        r_go_s1, r_go_s2, r_sw_s1, r_sw_s2;
    logic [2:0]  r_vld;
    logic        r_go_act;
    logic [23:0] r_eat_tmr, r_btn_tmr;
    logic        w_btn_evt, w_eat_evt;
    tone_t       r_sel, w_sel, r_cur;
    logic [17:0] r_phase, w_half_m1;
    logic        r_pwm, r_sd;

    // Two-flop synchronizers plus previous-sample registers; r_vld marks when
    // r_ate_prev holds a real sample so the first ate value is not an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_s1   <= '0;
            r_btn_s2   <= '0;
            r_btn_prev <= '0;
            r_ate_s1   <= '0;
            r_ate_s2   <= '0;
            r_ate_prev <= '0;
            r_go_s1    <= 1'b0;
            r_go_s2    <= 1'b0;
            r_sw_s1    <= 1'b0;
            r_sw_s2    <= 1'b0;
            r_vld      <= '0;
        end else begin
            r_btn_s1   <= pbttn;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
            r_ate_s1   <= ate;
            r_ate_s2   <= r_ate_s1;
            r_ate_prev <= r_ate_s2;
            r_go_s1    <= gameover;
            r_go_s2    <= r_go_s1;
            r_sw_s1    <= switch_screen;
            r_sw_s2    <= r_sw_s1;
            r_vld      <= {r_vld[1:0], 1'b1};
        end
    end

    assign w_btn_evt = |(r_btn_s2 & ~r_btn_prev);
    assign w_eat_evt = r_vld[2] && (r_ate_s2 != r_ate_prev);

    // Effect timers: load on event (retrigger), count down, saturate at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_eat_tmr <= '0;
            r_btn_tmr <= '0;
            r_go_act  <= 1'b0;
        end else begin
            if (w_eat_evt) begin
                r_eat_tmr <= c_eat_dur;
            end else if (r_eat_tmr != '0) begin
                r_eat_tmr <= r_eat_tmr - 24'd1;
            end
            if (w_btn_evt) begin
                r_btn_tmr <= c_btn_dur;
            end else if (r_btn_tmr != '0) begin
                r_btn_tmr <= r_btn_tmr - 24'd1;
            end
            // Matches the event-detect stage so every source has equal latency.
            r_go_act <= r_go_s2 & r_sw_s2;
        end
    end

    // Tone select state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel <= TONE_SILENT;
        end else begin
            r_sel <= w_sel;
        end
    end

    // Next tone: fixed priority game-over > eat > button > silent.
    always_comb begin
        w_sel = TONE_SILENT;
        if (r_go_act) begin
            w_sel = TONE_GO;
        end else if (r_eat_tmr != '0) begin
            w_sel = TONE_EAT;
        end else if (r_btn_tmr != '0) begin
            w_sel = TONE_BTN;
        end
    end

    // Half-period of the tone currently being played.
    always_comb begin
        w_half_m1 = '0;
        case (r_cur)
            TONE_GO:  w_half_m1 = c_go_half_m1;
            TONE_EAT: w_half_m1 = c_eat_half_m1;
            TONE_BTN: w_half_m1 = c_btn_half_m1;
            default:  w_half_m1 = '0;
        endcase
    end

    // Square-wave generator: restart high on tone change, toggle every half.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur   <= TONE_SILENT;
            r_phase <= '0;
            r_pwm   <= 1'b0;
            r_sd    <= 1'b0;
        end else begin
            r_sd <= c_sd_on;
            if (r_sel != r_cur) begin
                r_cur   <= r_sel;
                r_phase <= '0;
                r_pwm   <= (r_sel != TONE_SILENT);
            end else if (r_cur == TONE_SILENT) begin
                r_phase <= '0;
                r_pwm   <= 1'b0;
            end else if (r_phase == w_half_m1) begin
                r_phase <= '0;
                r_pwm   <= ~r_pwm;
            end else begin
                r_phase <= r_phase + 18'd1;
            end
        end
    end

    assign AUD_PWM = r_pwm;
    assign AUD_SD  = r_sd;

endmodule
`default_nettype wire

// File: tb/tb_snake_audio.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_audio
// Brief    : Directed self-checking bench for snake_audio using the small
//            timing parameters (GO 8, EAT 4, BTN 2, EAT_DUR 40, BTN_DUR 20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_audio;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pbttn;
    logic        switch_screen;
    logic        gameover;
    logic [15:0] ate;
    logic        AUD_PWM;
    logic        AUD_SD;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snake_audio #(
        .CLK_HZ   (100_000_000),
        .GO_HALF  (8),
        .EAT_HALF (4),
        .BTN_HALF (2),
        .EAT_DUR  (40),
        .BTN_DUR  (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pbttn         (pbttn),
        .switch_screen (switch_screen),
        .gameover      (gameover),
        .ate           (ate),
        .AUD_PWM       (AUD_PWM),
        .AUD_SD        (AUD_SD)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges and sample 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected output k cycles after the first high sample of a tone.
    function automatic logic wave(input int k, input int half);
        return ((k / half) % 2) == 0;
    endfunction

    task automatic play(input string tag, input int half, input int len);
        for (int k = 0; k < len; k++) begin
            check(tag, AUD_PWM, wave(k, half));
            tick(1);
        end
        check({tag, "_end"}, AUD_PWM, 1'b0);
    endtask

    task automatic quiet(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check(tag, AUD_PWM, 1'b0);
            tick(1);
        end
    endtask

    initial begin
        // Reset held with busy inputs: outputs forced low.
        reset = 1'b0; pbttn = 5'h1F; switch_screen = 1'b1; gameover = 1'b1; ate = 16'h0000;
        #2;
        check("rst_pwm", AUD_PWM, 1'b0);
        check("rst_sd", AUD_SD, 1'b0);
        tick(4);
        check("rst_pwm_held", AUD_PWM, 1'b0);
        check("rst_sd_held", AUD_SD, 1'b0);
        @(negedge clk); pbttn = 5'h00; gameover = 1'b0;
        tick(2);
        @(negedge clk); reset = 1'b1;
        tick(1);
        check("sd_release", AUD_SD, 1'b1);
        check("pwm_release", AUD_PWM, 1'b0);
        quiet("idle_after_reset", 20);

        // One-cycle button pulse: click of period 4 for 20 cycles.
        @(negedge clk); pbttn = 5'h01;
        tick(1);
        @(negedge clk); pbttn = 5'h00;
        tick(3);
        check("btn_latency", AUD_PWM, 1'b0);
        tick(1);
        play("btn_click", 2, 20);
        quiet("btn_after", 5);

        // Held button: one click only.
        @(negedge clk); pbttn = 5'h10;
        tick(4);
        check("hold_latency", AUD_PWM, 1'b0);
        tick(1);
        play("btn_hold", 2, 20);
        quiet("btn_hold_once", 20);
        @(negedge clk); pbttn = 5'h00;
        quiet("btn_release", 10);

        // Eat chirp: period 8 for 40 cycles.
        @(negedge clk); ate = 16'h0001;
        tick(4);
        check("eat_latency", AUD_PWM, 1'b0);
        tick(1);
        play("eat_chirp", 4, 40);
        quiet("eat_after", 5);

        // Retrigger at cycle 20: chirp ends 40 cycles after the second event.
        @(negedge clk); ate = 16'h0003;
        tick(5);
        for (int k = 0; k < 60; k++) begin
            check("eat_retrig", AUD_PWM, wave(k, 4));
            if (k == 15) begin
                @(negedge clk); ate = 16'h0007;
            end
            tick(1);
        end
        check("eat_retrig_end", AUD_PWM, 1'b0);
        quiet("eat_retrig_after", 5);

        // Game-over drone on the map screen, then release.
        @(negedge clk); gameover = 1'b1;
        tick(4);
        check("go_latency", AUD_PWM, 1'b0);
        tick(1);
        for (int k = 0; k < 49; k++) begin
            check("go_tone", AUD_PWM, wave(k, 8));
            if (k < 48) tick(1);
        end
        @(negedge clk); gameover = 1'b0;
        for (int k = 49; k < 52; k++) begin
            tick(1);
            check("go_tail", AUD_PWM, wave(k, 8));
        end
        tick(2);
        quiet("go_release", 20);

        // Game-over on the start screen: silent.
        @(negedge clk); switch_screen = 1'b0; gameover = 1'b1;
        quiet("go_start_screen", 30);
        @(negedge clk); gameover = 1'b0;
        tick(3);
        @(negedge clk); switch_screen = 1'b1;
        quiet("screen_back", 8);

        // Game-over masks an eat event; chirp expires while masked.
        @(negedge clk); gameover = 1'b1;
        tick(5);
        for (int k = 0; k < 49; k++) begin
            check("go_over_eat", AUD_PWM, wave(k, 8));
            if (k == 2) begin
                @(negedge clk); ate = 16'h0008;
            end
            if (k < 48) tick(1);
        end
        @(negedge clk); gameover = 1'b0;
        for (int k = 49; k < 52; k++) begin
            tick(1);
            check("go_over_eat_tail", AUD_PWM, wave(k, 8));
        end
        tick(2);
        quiet("go_over_eat_release", 20);

        // Simultaneous eat and button: eat heard, then silence.
        @(negedge clk); ate = 16'h0010; pbttn = 5'h04;
        tick(1);
        @(negedge clk); pbttn = 5'h00;
        tick(3);
        check("both_latency", AUD_PWM, 1'b0);
        tick(1);
        play("eat_btn", 4, 40);
        quiet("eat_btn_after", 10);

        // Reset during a chirp silences at once; no event afterwards.
        @(negedge clk); ate = 16'h0020;
        tick(5);
        for (int k = 0; k < 11; k++) begin
            check("pre_reset_chirp", AUD_PWM, wave(k, 4));
            if (k < 10) tick(1);
        end
        #2; reset = 1'b0; ate = 16'h0040;
        #1;
        check("rst_async_pwm", AUD_PWM, 1'b0);
        check("rst_async_sd", AUD_SD, 1'b0);
        tick(3);
        @(negedge clk); reset = 1'b1;
        tick(1);
        check("sd_release2", AUD_SD, 1'b1);
        quiet("post_reset", 40);
        check("sd_final", AUD_SD, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
